// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath: single-bus 32-bit CPU datapath (phase 1).
//
// Holds R0-R15, PC, HI, LO, Y, Z (64-bit), MAR, MDR, InPort and C. Every
// register source shares one 32-bit bus (BusMuxOut), selected by per-register
// out-enables with fixed priority. A combinational ALU computes a 64-bit
// result from Y (operand A) and the bus (operand B); Z captures it on Zin.
// Sequencing of strobes is done by an external control unit.
//
// Ports
//   clk, clr               clock, synchronous active-low reset
//   R0in..R15in            load GPR from bus
//   PCin, HIin, LOin, Yin  load PC/HI/LO/Y from bus
//   Zin                    load Z from ALU result
//   MARin, Cin             load MAR/C from bus
//   MDRin, Read            load MDR from Mdatain (Read=1) or bus (Read=0)
//   InPortin               load InPort from Mdatain
//   incPC                  ALU override: result = bus + 1
//   opcode[4:0]            ALU operation select
//   Mdatain[31:0]          memory read data
//   R0out..R15out, HIout, LOout, PCout, MDRout, InPortOut, Cout,
//   ZHighOut, ZLowOut      bus out-enables
//   BusMuxOut[31:0]        current bus value (combinational)
//   MARdata[31:0]          MAR contents
//
// Bus handshake: there is no valid/ready flow control; a transfer is the
// out-enable and the in-strobe asserted in the same cycle, completing at the
// next rising edge of clk.
// -----------------------------------------------------------------------------
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             R0in,  R1in,  R2in,  R3in,
  input  logic             R4in,  R5in,  R6in,  R7in,
  input  logic             R8in,  R9in,  R10in, R11in,
  input  logic             R12in, R13in, R14in, R15in,
  input  logic             PCin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             Yin,
  input  logic             Zin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             Read,
  input  logic             InPortin,
  input  logic             Cin,
  input  logic             incPC,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             R0out,  R1out,  R2out,  R3out,
  input  logic             R4out,  R5out,  R6out,  R7out,
  input  logic             R8out,  R9out,  R10out, R11out,
  input  logic             R12out, R13out, R14out, R15out,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             PCout,
  input  logic             MDRout,
  input  logic             InPortOut,
  input  logic             Cout,
  input  logic             ZHighOut,
  input  logic             ZLowOut,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] MARdata
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_ROL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_NEG  = 5'b01110;
  localparam logic [4:0] OP_NOT  = 5'b01111;

  logic [15:0] r_in, r_out;
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  logic [WIDTH-1:0]   r [16];
  logic [WIDTH-1:0]   pc, hi, lo, y, mar, mdr, inport, c;
  logic [2*WIDTH-1:0] z;
  logic [2*WIDTH-1:0] alu_res;
  logic [WIDTH-1:0]   bus;

  // ---------------------------------------------------------------- bus
  // Assignments run from lowest to highest priority so the last enabled
  // source written (R0 ultimately) wins.
  always_comb begin
    bus = '0;
    if (Cout)      bus = c;
    if (InPortOut) bus = inport;
    if (MDRout)    bus = mdr;
    if (PCout)     bus = pc;
    if (ZLowOut)   bus = z[WIDTH-1:0];
    if (ZHighOut)  bus = z[2*WIDTH-1:WIDTH];
    if (LOout)     bus = lo;
    if (HIout)     bus = hi;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) bus = r[i];
    end
  end

  assign BusMuxOut = bus;
  assign MARdata   = mar;

  // ---------------------------------------------------------------- ALU
  logic [4:0]         sh;
  logic [2*WIDTH-1:0] rot_l, rot_r, a_ext, b_ext;
  logic signed [WIDTH-1:0] quo, rem;

  assign sh    = bus[4:0];
  // Rotates via a doubled copy of A: the wanted window falls out of one shift.
  assign rot_l = {y, y} << sh;
  assign rot_r = {y, y} >> sh;
  // Sign-extended 64-bit operands: the low 64 bits of their unsigned product
  // equal the signed 32x32 product.
  assign a_ext = {{WIDTH{y[WIDTH-1]}}, y};
  assign b_ext = {{WIDTH{bus[WIDTH-1]}}, bus};
  assign quo   = $signed(y) / $signed(bus);
  assign rem   = $signed(y) % $signed(bus);

  always_comb begin
    alu_res = '0;
    if (incPC) begin
      alu_res = {{WIDTH{1'b0}}, bus + 1'b1};
    end else begin
      unique case (opcode)
        OP_ADD:  alu_res = {{WIDTH{1'b0}}, y + bus};
        OP_SUB:  alu_res = {{WIDTH{1'b0}}, y - bus};
        OP_AND:  alu_res = {{WIDTH{1'b0}}, y & bus};
        OP_OR:   alu_res = {{WIDTH{1'b0}}, y | bus};
        OP_NEG:  alu_res = {{WIDTH{1'b0}}, (~bus) + 1'b1};
        OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~bus};
        OP_ROL:  alu_res = {{WIDTH{1'b0}}, rot_l[2*WIDTH-1:WIDTH]};
        OP_ROR:  alu_res = {{WIDTH{1'b0}}, rot_r[WIDTH-1:0]};
        OP_SHR:  alu_res = {{WIDTH{1'b0}}, y >> sh};
        OP_SHRA: alu_res = {{WIDTH{1'b0}}, WIDTH'($signed(y) >>> sh)};
        OP_SHL:  alu_res = {{WIDTH{1'b0}}, y << sh};
        OP_MUL:  alu_res = a_ext * b_ext;
        // Divide by zero yields remainder = A, quotient = all ones.
        OP_DIV:  alu_res = (bus == '0) ? {y, {WIDTH{1'b1}}}
                                       : {WIDTH'(rem), WIDTH'(quo)};
        default: alu_res = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- registers
  for (genvar gi = 0; gi < 16; gi++) begin : g_gpr
    always_ff @(posedge clk) begin
      if (!clr)          r[gi] <= '0;
      else if (r_in[gi]) r[gi] <= bus;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      pc     <= '0;
      hi     <= '0;
      lo     <= '0;
      y      <= '0;
      z      <= '0;
      mar    <= '0;
      mdr    <= '0;
      inport <= '0;
      c      <= '0;
    end else begin
      if (PCin)     pc     <= bus;
      if (HIin)     hi     <= bus;
      if (LOin)     lo     <= bus;
      if (Yin)      y      <= bus;
      if (Zin)      z      <= alu_res;
      if (MARin)    mar    <= bus;
      if (MDRin)    mdr    <= Read ? Mdatain : bus;
      if (InPortin) inport <= Mdatain;
      if (Cin)      c      <= bus;
    end
  end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] rin, rout;
  logic        pc_in, hi_in, lo_in, y_in, z_in, mar_in, mdr_in, rd, inport_in, c_in;
  logic        inc_pc;
  logic [4:0]  opcode;
  logic [31:0] mdatain;
  logic        hi_out, lo_out, pc_out, mdr_out, inport_out, c_out, zh_out, zl_out;
  logic [31:0] bus, mar_data;

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------------ clock/reset
  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .clr(clr),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .PCin(pc_in), .HIin(hi_in), .LOin(lo_in), .Yin(y_in), .Zin(z_in),
    .MARin(mar_in), .MDRin(mdr_in), .Read(rd), .InPortin(inport_in), .Cin(c_in),
    .incPC(inc_pc), .opcode(opcode), .Mdatain(mdatain),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(hi_out), .LOout(lo_out), .PCout(pc_out), .MDRout(mdr_out),
    .InPortOut(inport_out), .Cout(c_out), .ZHighOut(zh_out), .ZLowOut(zl_out),
    .BusMuxOut(bus), .MARdata(mar_data)
  );

  // ------------------------------------------------------------ driver tasks
  task automatic idle();
    rin = '0; rout = '0;
    pc_in = 0; hi_in = 0; lo_in = 0; y_in = 0; z_in = 0; mar_in = 0;
    mdr_in = 0; rd = 0; inport_in = 0; c_in = 0; inc_pc = 0; opcode = '0;
    mdatain = '0;
    hi_out = 0; lo_out = 0; pc_out = 0; mdr_out = 0; inport_out = 0;
    c_out = 0; zh_out = 0; zl_out = 0;
  endtask

  // One edge with the currently driven strobes, then release them.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Caller drives out-enables; this samples the bus mid-cycle and releases.
  task automatic peek(input string tag, input logic [31:0] exp);
    #1;
    check(tag, bus, exp);
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] val);
    mdatain = val; rd = 1; mdr_in = 1;
    tick();
  endtask

  task automatic load_r(input int idx, input logic [31:0] val);
    load_mdr(val);
    mdr_out = 1; rin[idx] = 1;
    tick();
  endtask

  task automatic peek_r(input int idx, input string tag, input logic [31:0] exp);
    rout[idx] = 1;
    peek(tag, exp);
  endtask

  // Y <= a via MDR, then bus <= b via MDR with the given op into Z.
  task automatic alu(input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] op, input logic inc);
    load_mdr(a);
    mdr_out = 1; y_in = 1;
    tick();
    load_mdr(b);
    mdr_out = 1; opcode = op; inc_pc = inc; z_in = 1;
    tick();
  endtask

  task automatic check_z(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    zh_out = 1;
    peek({tag, "_zhi"}, exp_hi);
    zl_out = 1;
    peek({tag, "_zlo"}, exp_lo);
  endtask

  // ------------------------------------------------------------ directed vectors
  initial begin
    idle();
    clr = 0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1;

    peek("bus_idle_after_reset", 32'h0);

    // Reset clears everything and beats a simultaneous load.
    load_r(5, 32'd7);
    peek_r(5, "r5_loaded", 32'd7);
    clr = 0; mdr_out = 1; rin[5] = 1; pc_in = 1;
    tick();
    clr = 1;
    peek_r(5, "r5_after_reset", 32'd0);
    pc_out = 1;  peek("pc_after_reset", 32'd0);
    mdr_out = 1; peek("mdr_after_reset", 32'd0);
    check_z("z_after_reset", 32'd0, 32'd0);
    peek("bus_no_enable", 32'd0);

    // Load path through MDR.
    load_mdr(32'd32);
    mdr_out = 1; peek("mdr_32", 32'd32);
    mdr_out = 1; rin[6] = 1; tick();
    peek_r(6, "r6_32", 32'd32);
    load_r(4, 32'd2);
    peek_r(4, "r4_2", 32'd2);

    // ROL R6 by R4 through Y/Z, write back.
    rout[6] = 1; y_in = 1; tick();
    rout[4] = 1; opcode = 5'b00110; z_in = 1; tick();
    check_z("rol_32_2", 32'd0, 32'd128);
    zl_out = 1; rin[6] = 1; tick();
    peek_r(6, "r6_128", 32'd128);
    alu(32'h80000001, 32'd1, 5'b00110, 1'b0);
    check_z("rol_wrap", 32'd0, 32'h00000003);
    alu(32'h00000001, 32'd1, 5'b00111, 1'b0);
    check_z("ror_wrap", 32'd0, 32'h80000000);

    // PC increment; incPC overrides a live AND opcode.
    pc_out = 1; inc_pc = 1; opcode = 5'b00101; z_in = 1; mar_in = 1;
    tick();
    check("mar_pc0", mar_data, 32'd0);
    check_z("inc_pc", 32'd0, 32'd1);
    zl_out = 1; pc_in = 1; tick();
    pc_out = 1; peek("pc_1", 32'd1);
    alu(32'd0, 32'hFFFFFFFF, 5'b00000, 1'b1);
    check_z("inc_wrap", 32'd0, 32'd0);

    // Arithmetic / logic.
    alu(32'd5, 32'd3, 5'b00011, 1'b0);            check_z("add", 32'd0, 32'd8);
    alu(32'hFFFFFFFF, 32'd1, 5'b00011, 1'b0);     check_z("add_wrap", 32'd0, 32'd0);
    alu(32'd3, 32'd5, 5'b00100, 1'b0);            check_z("sub", 32'd0, 32'hFFFFFFFE);
    alu(32'hF0F0F0F0, 32'hFF00FF00, 5'b00101, 1'b0); check_z("and", 32'd0, 32'hF000F000);
    alu(32'hF0F0F0F0, 32'h0F000F00, 5'b01000, 1'b0); check_z("or", 32'd0, 32'hFFF0FFF0);
    alu(32'd0, 32'd5, 5'b01110, 1'b0);            check_z("neg", 32'd0, 32'hFFFFFFFB);
    alu(32'd0, 32'h0000FFFF, 5'b01111, 1'b0);     check_z("not", 32'd0, 32'hFFFF0000);
    alu(32'h80000000, 32'd4, 5'b01010, 1'b0);     check_z("shra", 32'd0, 32'hF8000000);
    alu(32'h80000000, 32'd4, 5'b01001, 1'b0);     check_z("shr", 32'd0, 32'h08000000);
    alu(32'h00000003, 32'd31, 5'b01011, 1'b0);    check_z("shl", 32'd0, 32'h80000000);
    alu(32'h12345678, 32'h9ABCDEF0, 5'b00000, 1'b0); check_z("bad_op", 32'd0, 32'd0);

    // MUL / DIV.
    alu(32'hFFFFFFE0, 32'd2, 5'b01100, 1'b0);     check_z("mul_neg", 32'hFFFFFFFF, 32'hFFFFFFC0);
    alu(32'h00010000, 32'h00010000, 5'b01100, 1'b0); check_z("mul_big", 32'h00000001, 32'd0);
    alu(32'hFFFFFFF9, 32'd2, 5'b01101, 1'b0);     check_z("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    alu(32'd7, 32'd0, 5'b01101, 1'b0);            check_z("div_zero", 32'd7, 32'hFFFFFFFF);
    alu(32'd7, 32'd2, 5'b01101, 1'b0);            check_z("div", 32'd1, 32'd3);

    // HI/LO from Z halves, C and InPort.
    zh_out = 1; hi_in = 1; tick();
    zl_out = 1; lo_in = 1; tick();
    hi_out = 1; peek("hi", 32'd1);
    lo_out = 1; peek("lo", 32'd3);
    load_mdr(32'hCAFE0001);
    mdr_out = 1; c_in = 1; tick();
    c_out = 1; peek("c", 32'hCAFE0001);
    mdatain = 32'h00000055; inport_in = 1; tick();
    inport_out = 1; peek("inport", 32'h55);

    // Priority.
    load_r(1, 32'h11);
    load_r(2, 32'h22);
    rout[1] = 1; rout[2] = 1; peek("prio_r1_r2", 32'h11);
    rout[15] = 1; hi_out = 1; peek("prio_r15_hi", 32'd0);
    hi_out = 1; c_out = 1; lo_out = 1; peek("prio_hi_lo_c", 32'd1);
    zl_out = 1; pc_out = 1; mdr_out = 1; peek("prio_zlo_pc", 32'd3);
    inport_out = 1; c_out = 1; peek("prio_inport_c", 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
